dmem_result_reader: RTL and testbench



---
 rtl/dmem_result_reader.sv | 136 +++++++++++++
 tb/tb_dmem_result_reader.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_result_reader.sv
// Sweeps a range of data-memory words and streams their low OUT_W bits over valid/ready.
// Define DMEM_RESULT_READER_CHECK_EN to compile in the Fibonacci stream checker.
module dmem_result_reader #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32,
  parameter int OUT_W  = 16,
  parameter int CNT_W  = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  count,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [OUT_W-1:0]  out_data,
  output logic [CNT_W-1:0]  out_index,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic              mismatch,
  output logic [CNT_W-1:0]  err_index
);

  // state  | meaning
  // IDLE   | waiting for start
  // FETCH  | first word read from memory into the output register
  // SEND   | word presented; advance on each handshake
  // FIN    | done pulse, then back to IDLE
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_SEND, S_FIN} state_t;

  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  state_t            state;
  logic [CNT_W-1:0]  remaining;
  logic              handshake;

  assign handshake = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      mem_addr  <= '0;
      out_data  <= '0;
      out_index <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      remaining <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (count != '0) begin
              mem_addr  <= base_addr;
              remaining <= count;
              out_index <= '0;
              state     <= S_FETCH;
            end else begin
              done  <= 1'b1;
              state <= S_FIN;
            end
          end
        end
        S_FETCH: begin
          out_data  <= mem_rdata[OUT_W-1:0];
          out_valid <= 1'b1;
          mem_addr  <= mem_addr + ADDR_ONE;
          state     <= S_SEND;
        end
        S_SEND: begin
          if (handshake) begin
            remaining <= remaining - CNT_ONE;
            if (remaining == CNT_ONE) begin
              out_valid <= 1'b0;
              done      <= 1'b1;
              state     <= S_FIN;
            end else begin
              // mem_addr already points at the next word, so its data is on mem_rdata now
              out_data  <= mem_rdata[OUT_W-1:0];
              mem_addr  <= mem_addr + ADDR_ONE;
              out_index <= out_index + CNT_ONE;
            end
          end
        end
        S_FIN: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  generate
    if (DATA_W > OUT_W) begin : g_hi_bits
      logic unused_hi;
      assign unused_hi = ^mem_rdata[DATA_W-1:OUT_W];
    end
  endgenerate

`ifdef DMEM_RESULT_READER_CHECK_EN
  logic [31:0] fib_a;
  logic [31:0] fib_b;

  always_ff @(posedge clk) begin
    if (reset) begin
      fib_a     <= 32'd0;
      fib_b     <= 32'd1;
      mismatch  <= 1'b0;
      err_index <= '0;
    end else if (state == S_IDLE && start) begin
      fib_a     <= 32'd0;
      fib_b     <= 32'd1;
      mismatch  <= 1'b0;
      err_index <= '0;
    end else if (state == S_SEND && handshake) begin
      // only the first bad word is recorded
      if (out_data != fib_a[OUT_W-1:0] && !mismatch) begin
        mismatch  <= 1'b1;
        err_index <= out_index;
      end
      fib_a <= fib_b;
      fib_b <= fib_a + fib_b;
    end
  end
`else
  assign mismatch  = 1'b0;
  assign err_index = '0;
`endif

endmodule

// File: tb/tb_dmem_result_reader.sv
// Scoreboard bench for dmem_result_reader: directed sweeps, stalls, wrap, count=0, checker, reset.
module tb_dmem_result_reader;
  localparam int ADDR_W = 9;
  localparam int DATA_W = 32;
  localparam int OUT_W  = 16;
  localparam int CNT_W  = 10;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [CNT_W-1:0]  count;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic [OUT_W-1:0]  out_data;
  logic [CNT_W-1:0]  out_index;
  logic              out_valid;
  logic              out_ready;
  logic              busy;
  logic              done;
  logic              mismatch;
  logic [CNT_W-1:0]  err_index;

  dmem_result_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .OUT_W(OUT_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .count(count),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata), .out_data(out_data), .out_index(out_index),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .done(done),
    .mismatch(mismatch), .err_index(err_index)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:511];
  assign mem_rdata = mem[mem_addr];

  typedef struct packed {
    logic [OUT_W-1:0] data;
    logic [CNT_W-1:0] idx;
  } beat_t;

  beat_t exp_q[$];
  int    vectors = 0;
  int    miscompares = 0;
  int    beats = 0;
  int    ready_mode = 0;
  int    fib_tab [10] = '{0, 1, 1, 2, 3, 5, 8, 13, 21, 34};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push_beat(input int data, input int idx);
    beat_t b;
    b.data = OUT_W'(data);
    b.idx  = CNT_W'(idx);
    exp_q.push_back(b);
  endtask

  // monitor: pops the scoreboard on each handshake, checks hold while stalled
  logic             stall_prev = 1'b0;
  logic [OUT_W-1:0] held_d;
  logic [CNT_W-1:0] held_i;
  always @(negedge clk) begin
    beat_t e;
    if (reset) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_data", 32'(out_data), 32'(held_d));
        check("stall_index", 32'(out_index), 32'(held_i));
      end
      if (out_valid && out_ready) begin
        beats++;
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_beat: got data %0d index %0d with nothing expected", out_data, out_index);
        end else begin
          e = exp_q.pop_front();
          check("beat_data", 32'(out_data), 32'(e.data));
          check("beat_index", 32'(out_index), 32'(e.idx));
        end
      end
      stall_prev = out_valid && !out_ready;
      held_d = out_data;
      held_i = out_index;
    end
  end

  // ready driver: 0 = always high, 1 = 1,0,0 pattern, 2 = held low
  initial begin
    int ph = 0;
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (ph % 3 == 0);
        default: out_ready = 1'b0;
      endcase
      ph++;
    end
  end

  task automatic pulse_start(input logic [ADDR_W-1:0] b, input logic [CNT_W-1:0] c);
    @(posedge clk);
    #1;
    start = 1'b1;
    base_addr = b;
    count = c;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit, input string name);
    bit seen = 1'b0;
    for (int n = 0; n < limit; n++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    check({name, "_done_seen"}, 32'(seen), 32'd1);
  endtask

  task automatic check_reset_values(input string name);
    check({name, "_mem_addr"}, 32'(mem_addr), 32'd0);
    check({name, "_out_data"}, 32'(out_data), 32'd0);
    check({name, "_out_index"}, 32'(out_index), 32'd0);
    check({name, "_out_valid"}, 32'(out_valid), 32'd0);
    check({name, "_busy"}, 32'(busy), 32'd0);
    check({name, "_done"}, 32'(done), 32'd0);
    check({name, "_mismatch"}, 32'(mismatch), 32'd0);
    check({name, "_err_index"}, 32'(err_index), 32'd0);
  endtask

  task automatic push_fib(input int bad_idx, input int bad_val);
    for (int i = 0; i < 10; i++) push_beat((i == bad_idx) ? bad_val : fib_tab[i], i);
  endtask

  initial begin
    int b0;
    bit seen;
    reset = 1'b1;
    start = 1'b0;
    base_addr = '0;
    count = '0;
    for (int i = 0; i < 512; i++) mem[i] = 32'd0;
    for (int i = 0; i < 10; i++) mem[i] = 32'(fib_tab[i]) | 32'hABCD_0000;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    reset = 1'b0;

    // continuous ready: latency, 10 back-to-back beats, done/busy timing
    push_fib(-1, 0);
    b0 = beats;
    pulse_start(9'd0, 10'd10);
    @(negedge clk);
    check("t1_fetch_valid", 32'(out_valid), 32'd0);
    check("t1_fetch_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t1_valid_run", 32'(out_valid), 32'd1);
      if (i == 0) check("t1_addr_after_fetch", 32'(mem_addr), 32'd1);
    end
    @(negedge clk);
    check("t1_done", 32'(done), 32'd1);
    check("t1_fin_busy", 32'(busy), 32'd1);
    check("t1_fin_valid", 32'(out_valid), 32'd0);
    check("t1_mismatch", 32'(mismatch), 32'd0);
    @(negedge clk);
    check("t1_done_pulse", 32'(done), 32'd0);
    check("t1_busy_fall", 32'(busy), 32'd0);
    check("t1_beats", 32'(beats - b0), 32'd10);
    check("t1_drained", 32'(exp_q.size()), 32'd0);

    // toggling ready
    ready_mode = 1;
    push_fib(-1, 0);
    b0 = beats;
    pulse_start(9'd0, 10'd10);
    wait_done(100, "t2");
    check("t2_beats", 32'(beats - b0), 32'd10);
    check("t2_drained", 32'(exp_q.size()), 32'd0);
    ready_mode = 0;

    // count = 0
    b0 = beats;
    pulse_start(9'd0, 10'd0);
    @(negedge clk);
    check("t3_done", 32'(done), 32'd1);
    check("t3_busy", 32'(busy), 32'd1);
    check("t3_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("t3_done_pulse", 32'(done), 32'd0);
    check("t3_busy_fall", 32'(busy), 32'd0);
    check("t3_beats", 32'(beats - b0), 32'd0);

    // corrupted word 3
    mem[3] = 32'd5;
    push_fib(3, 5);
    pulse_start(9'd0, 10'd10);
    wait_done(40, "t4");
`ifdef DMEM_RESULT_READER_CHECK_EN
    check("t4_mismatch", 32'(mismatch), 32'd1);
    check("t4_err_index", 32'(err_index), 32'd3);
    @(negedge clk);
    check("t4_mismatch_hold", 32'(mismatch), 32'd1);
    check("t4_err_hold", 32'(err_index), 32'd3);
`else
    check("t4_mismatch", 32'(mismatch), 32'd0);
    check("t4_err_index", 32'(err_index), 32'd0);
`endif
    mem[3] = 32'd2;
    push_fib(-1, 0);
    pulse_start(9'd0, 10'd10);
    check("t4_cleared", 32'(mismatch), 32'd0);
    wait_done(40, "t4b");
    check("t4b_mismatch", 32'(mismatch), 32'd0);
    check("t4b_drained", 32'(exp_q.size()), 32'd0);

    // reset while a word is held in SEND
    ready_mode = 2;
    push_fib(-1, 0);
    pulse_start(9'd0, 10'd10);
    @(negedge clk);
    @(negedge clk);
    check("t5_stalled_valid", 32'(out_valid), 32'd1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_reset_values("t5");
    reset = 1'b0;
    exp_q.delete();
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check("t5_no_done", 32'(seen), 32'd0);
    ready_mode = 0;
    push_fib(-1, 0);
    b0 = beats;
    pulse_start(9'd0, 10'd10);
    wait_done(40, "t5b");
    check("t5b_beats", 32'(beats - b0), 32'd10);
    check("t5b_drained", 32'(exp_q.size()), 32'd0);

    // address wrap 510 -> 511 -> 0 -> 1
    mem[510] = 32'd7;
    mem[511] = 32'd8;
    mem[0]   = 32'd9;
    mem[1]   = 32'd10;
    push_beat(7, 0);
    push_beat(8, 1);
    push_beat(9, 2);
    push_beat(10, 3);
    pulse_start(9'd510, 10'd4);
    @(negedge clk);
    check("t6_addr_base", 32'(mem_addr), 32'd510);
    @(negedge clk);
    check("t6_addr_511", 32'(mem_addr), 32'd511);
    @(negedge clk);
    check("t6_addr_wrap", 32'(mem_addr), 32'd0);
    wait_done(20, "t6");
    check("t6_drained", 32'(exp_q.size()), 32'd0);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
